// File: rtl/multicycle_main_fsm.sv
// Main control FSM for the multicycle RV32I core.
// Sequences the shared ALU through fetch/decode/address/execute phases,
// drives the ALU operand muxes, result mux and all write enables, stalls
// on the memory ready handshake and traps unsupported opcodes.
//
// state    | code | meaning
// ---------+------+----------------------------------------------------
// FETCH    |  0   | read instruction at PC, load IR/oldPC, PC <= PC+4
// DECODE   |  1   | read regs, oldPC+imm (branch target) into ALUOut
// MEMADR   |  2   | rs1+imm data address into ALUOut
// MEMREAD  |  3   | read data memory at ALUOut, wait for mem_ready
// MEMWB    |  4   | write loaded data to rd
// MEMWRITE |  5   | write rs2 to data memory, strobe held until mem_ready
// EXECR    |  6   | rs1 op rs2 (funct-decoded)
// EXECI    |  7   | rs1 op imm (funct-decoded)
// ALUWB    |  8   | write ALUOut to rd
// BEQ      |  9   | rs1-rs2 compare, PC <= ALUOut when zero
// JAL      | 10   | PC <= ALUOut (target), oldPC+4 into ALUOut for rd
// ILLEGAL  | 11   | unsupported opcode, parked until reset
// 12..15   |  -   | unreachable; return to FETCH with enables off

module multicycle_main_fsm #(
    parameter int STATE_W      = 4,
    parameter int FETCH_PC_INC = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic               zero,
    input  logic               mem_ready,
    output logic [1:0]         aluop,
    output logic [1:0]         alusrca,
    output logic [1:0]         alusrcb,
    output logic [1:0]         resultsrc,
    output logic               adrsrc,
    output logic               irwrite,
    output logic               pcwrite,
    output logic               regwrite,
    output logic               memwrite,
    output logic               illegal,
    output logic [STATE_W-1:0] state
);

    typedef enum logic [STATE_W-1:0] {
        S_FETCH    = 0,
        S_DECODE   = 1,
        S_MEMADR   = 2,
        S_MEMREAD  = 3,
        S_MEMWB    = 4,
        S_MEMWRITE = 5,
        S_EXECR    = 6,
        S_EXECI    = 7,
        S_ALUWB    = 8,
        S_BEQ      = 9,
        S_JAL      = 10,
        S_ILLEGAL  = 11
    } state_t;

    // Opcodes recognised by the decoder.
    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_RTYP = 7'b0110011;
    localparam logic [6:0] OP_ITYP = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    // ALU decoder control.
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // Operand A mux.
    localparam logic [1:0] SRCA_PC     = 2'b00;
    localparam logic [1:0] SRCA_OLDPC  = 2'b01;
    localparam logic [1:0] SRCA_RS1    = 2'b10;

    // Operand B mux. The datapath supplies the fetch increment on the
    // constant leg; the encoding of that leg does not depend on its value.
    localparam logic [1:0] SRCB_RS2    = 2'b00;
    localparam logic [1:0] SRCB_IMM    = 2'b01;
    localparam logic [1:0] SRCB_FOUR   = (FETCH_PC_INC == 4) ? 2'b10 : 2'b10;

    // Result mux.
    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALURES  = 2'b10;

    state_t state_q;
    state_t state_d;
    logic   illegal_q;

    // Ungated Moore strobes; the reset gate and branch resolution are
    // applied on the way out so that no write can fire in a reset cycle.
    logic   pcupdate;
    logic   branch;
    logic   irwrite_raw;
    logic   regwrite_raw;
    logic   memwrite_raw;

    // State register with synchronous reset; reset abandons any instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky trap flag: set once the FSM has sat in ILLEGAL, cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            illegal_q <= 1'b0;
        end else if (state_q == S_ILLEGAL) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state and Moore output decode.
    always_comb begin
        state_d      = S_FETCH;
        aluop        = ALUOP_ADD;
        alusrca      = SRCA_PC;
        alusrcb      = SRCB_RS2;
        resultsrc    = RES_ALUOUT;
        adrsrc       = 1'b0;
        pcupdate     = 1'b0;
        branch       = 1'b0;
        irwrite_raw  = 1'b0;
        regwrite_raw = 1'b0;
        memwrite_raw = 1'b0;

        case (state_q)
            S_FETCH: begin
                alusrca     = SRCA_PC;
                alusrcb     = SRCB_FOUR;
                aluop       = ALUOP_ADD;
                resultsrc   = RES_ALURES;
                adrsrc      = 1'b0;
                irwrite_raw = mem_ready;
                pcupdate    = mem_ready;
                state_d     = mem_ready ? S_DECODE : S_FETCH;
            end

            S_DECODE: begin
                alusrca = SRCA_OLDPC;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYP:      state_d = S_EXECR;
                    OP_ITYP:      state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end

            S_MEMADR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_ADD;
                // IR is stable here, so op still identifies load vs store.
                state_d = (op == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            end

            S_MEMREAD: begin
                resultsrc = RES_ALUOUT;
                adrsrc    = 1'b1;
                state_d   = mem_ready ? S_MEMWB : S_MEMREAD;
            end

            S_MEMWB: begin
                resultsrc    = RES_MEMDATA;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end

            S_MEMWRITE: begin
                resultsrc    = RES_ALUOUT;
                adrsrc       = 1'b1;
                memwrite_raw = 1'b1;
                state_d      = mem_ready ? S_FETCH : S_MEMWRITE;
            end

            S_EXECR: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end

            S_EXECI: begin
                alusrca = SRCA_RS1;
                alusrcb = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
                state_d = S_ALUWB;
            end

            S_ALUWB: begin
                resultsrc    = RES_ALUOUT;
                regwrite_raw = 1'b1;
                state_d      = S_FETCH;
            end

            S_BEQ: begin
                alusrca   = SRCA_RS1;
                alusrcb   = SRCB_RS2;
                aluop     = ALUOP_SUB;
                resultsrc = RES_ALUOUT;
                branch    = 1'b1;
                state_d   = S_FETCH;
            end

            S_JAL: begin
                alusrca   = SRCA_OLDPC;
                alusrcb   = SRCB_FOUR;
                aluop     = ALUOP_ADD;
                resultsrc = RES_ALUOUT;
                pcupdate  = 1'b1;
                state_d   = S_ALUWB;
            end

            S_ILLEGAL: begin
                state_d = S_ILLEGAL;
            end

            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // Write enables are suppressed whenever reset is asserted.
    assign irwrite  = irwrite_raw  & rst_n;
    assign regwrite = regwrite_raw & rst_n;
    assign memwrite = memwrite_raw & rst_n;
    assign pcwrite  = (pcupdate | (branch & zero)) & rst_n;

    assign illegal  = illegal_q;
    assign state    = state_q;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Directed bench for multicycle_main_fsm: a cycle-by-cycle vector table
// covering every instruction class, plus hand sequences for reset
// mid-instruction and the sticky illegal trap.

module tb_multicycle_main_fsm;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic [1:0] aluop;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       pcwrite;
    logic       regwrite;
    logic       memwrite;
    logic       illegal;
    logic [3:0] state;

    int checks = 0;
    int errors = 0;

    multicycle_main_fsm #(.STATE_W(4), .FETCH_PC_INC(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .op        (op),
        .zero      (zero),
        .mem_ready (mem_ready),
        .aluop     (aluop),
        .alusrca   (alusrca),
        .alusrcb   (alusrcb),
        .resultsrc (resultsrc),
        .adrsrc    (adrsrc),
        .irwrite   (irwrite),
        .pcwrite   (pcwrite),
        .regwrite  (regwrite),
        .memwrite  (memwrite),
        .illegal   (illegal),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst_n;
        logic [6:0] op;
        logic       zero;
        logic       mr;
        logic [3:0] st;
        logic [1:0] aluop;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] res;
        logic       adr;
        logic       ir;
        logic       pcw;
        logic       rw;
        logic       mw;
        logic       ill;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic [6:0] o, input logic z, input logic m,
                       input logic [3:0] s, input logic [1:0] ao, input logic [1:0] sa,
                       input logic [1:0] sb, input logic [1:0] rs, input logic ad,
                       input logic i, input logic p, input logic w, input logic mw,
                       input logic il);
        vec_t v;
        v.rst_n = r; v.op = o; v.zero = z; v.mr = m; v.st = s;
        v.aluop = ao; v.srca = sa; v.srcb = sb; v.res = rs; v.adr = ad;
        v.ir = i; v.pcw = p; v.rw = w; v.mw = mw; v.ill = il;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        op        = OP_R;
        zero      = 1'b0;
        mem_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        //   rst op      z  mr st  aluop srca srcb res adr ir pcw rw mw ill
        // R-type, no stalls: 0,1,6,8
        add(1, OP_R,   0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_R,   0, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_R,   0, 1, 6,  2, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_R,   0, 1, 8,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // lw with two read-stall cycles: 0,1,2,3,3,3,4
        add(1, OP_LW,  0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_LW,  0, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_LW,  0, 1, 2,  0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_LW,  0, 0, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, OP_LW,  0, 0, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, OP_LW,  0, 1, 3,  0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, OP_LW,  0, 1, 4,  0, 0, 0, 1, 0, 0, 0, 1, 0, 0);
        // sw with three fetch-stall cycles and two write-stall cycles
        add(1, OP_SW,  0, 0, 0,  0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        add(1, OP_SW,  0, 0, 0,  0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        add(1, OP_SW,  0, 0, 0,  0, 0, 2, 2, 0, 0, 0, 0, 0, 0);
        add(1, OP_SW,  0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_SW,  0, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_SW,  0, 1, 2,  0, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_SW,  0, 0, 5,  0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, OP_SW,  0, 0, 5,  0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        add(1, OP_SW,  0, 1, 5,  0, 0, 0, 0, 1, 0, 0, 0, 1, 0);
        // beq taken; zero high in DECODE must not write PC
        add(1, OP_BEQ, 0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_BEQ, 1, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_BEQ, 1, 1, 9,  1, 2, 0, 0, 0, 0, 1, 0, 0, 0);
        // beq not taken
        add(1, OP_BEQ, 0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_BEQ, 0, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_BEQ, 0, 1, 9,  1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        // jal: 0,1,10,8
        add(1, OP_JAL, 0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_JAL, 0, 1, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_JAL, 0, 1, 10, 0, 1, 2, 0, 0, 0, 1, 0, 0, 0);
        add(1, OP_JAL, 0, 1, 8,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // I-type; mem_ready low outside wait states must not stall
        add(1, OP_I,   0, 1, 0,  0, 0, 2, 2, 0, 1, 1, 0, 0, 0);
        add(1, OP_I,   0, 0, 1,  0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_I,   0, 0, 7,  2, 2, 1, 0, 0, 0, 0, 0, 0, 0);
        add(1, OP_I,   0, 0, 8,  0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, OP_I,   0, 0, 0,  0, 0, 2, 2, 0, 0, 0, 0, 0, 0);

        foreach (vecs[i]) begin
            rst_n     = vecs[i].rst_n;
            op        = vecs[i].op;
            zero      = vecs[i].zero;
            mem_ready = vecs[i].mr;
            #1;
            chk($sformatf("v%0d_state", i),     32'(state),     32'(vecs[i].st));
            chk($sformatf("v%0d_aluop", i),     32'(aluop),     32'(vecs[i].aluop));
            chk($sformatf("v%0d_alusrca", i),   32'(alusrca),   32'(vecs[i].srca));
            chk($sformatf("v%0d_alusrcb", i),   32'(alusrcb),   32'(vecs[i].srcb));
            chk($sformatf("v%0d_resultsrc", i), 32'(resultsrc), 32'(vecs[i].res));
            chk($sformatf("v%0d_adrsrc", i),    32'(adrsrc),    32'(vecs[i].adr));
            chk($sformatf("v%0d_irwrite", i),   32'(irwrite),   32'(vecs[i].ir));
            chk($sformatf("v%0d_pcwrite", i),   32'(pcwrite),   32'(vecs[i].pcw));
            chk($sformatf("v%0d_regwrite", i),  32'(regwrite),  32'(vecs[i].rw));
            chk($sformatf("v%0d_memwrite", i),  32'(memwrite),  32'(vecs[i].mw));
            chk($sformatf("v%0d_illegal", i),   32'(illegal),   32'(vecs[i].ill));
            chk($sformatf("v%0d_exclusive", i),
                32'((32'(irwrite) + 32'(regwrite) + 32'(memwrite)) <= 32'd1), 32'd1);
            tick();
        end

        // Reset asserted for two cycles while in EXECR.
        op        = OP_R;
        mem_ready = 1'b1;
        rst_n     = 1'b1;
        tick();
        tick();
        chk("rst_pre_state", 32'(state), 32'd6);
        rst_n = 1'b0;
        #1;
        chk("rst_cyc1_regwrite", 32'(regwrite), 32'd0);
        chk("rst_cyc1_memwrite", 32'(memwrite), 32'd0);
        chk("rst_cyc1_irwrite",  32'(irwrite),  32'd0);
        chk("rst_cyc1_pcwrite",  32'(pcwrite),  32'd0);
        tick();
        chk("rst_cyc2_state",    32'(state),    32'd0);
        chk("rst_cyc2_irwrite",  32'(irwrite),  32'd0);
        chk("rst_cyc2_illegal",  32'(illegal),  32'd0);
        tick();
        rst_n     = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("rst_post_state",    32'(state),    32'd0);
        chk("rst_post_irwrite0", 32'(irwrite),  32'd0);
        mem_ready = 1'b1;
        #1;
        chk("rst_post_irwrite1", 32'(irwrite),  32'd1);
        chk("rst_post_pcwrite1", 32'(pcwrite),  32'd1);

        // Unsupported opcode parks in ILLEGAL with the sticky flag set.
        op = OP_BAD;
        tick();
        chk("ill_decode_state",   32'(state),   32'd1);
        chk("ill_decode_illegal", 32'(illegal), 32'd0);
        tick();
        chk("ill_entry_state",    32'(state),   32'd11);
        chk("ill_entry_enables",
            32'({irwrite, pcwrite, regwrite, memwrite}), 32'd0);
        for (int k = 0; k < 10; k++) begin
            mem_ready = k[0];
            tick();
            chk($sformatf("ill_hold%0d_state", k),   32'(state),   32'd11);
            chk($sformatf("ill_hold%0d_illegal", k), 32'(illegal), 32'd1);
            chk($sformatf("ill_hold%0d_enables", k),
                32'({irwrite, pcwrite, regwrite, memwrite}), 32'd0);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        #1;
        chk("ill_clear_state",   32'(state),   32'd0);
        chk("ill_clear_illegal", 32'(illegal), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
